// File: rtl/dec38_seq.sv
// Sequential 3-to-8 one-hot decoder: codes arrive through a small FIFO, and each
// one is held on Q for a programmable dwell time, followed by a programmable blank gap.
module dec38_seq #(
    parameter int DEPTH   = 4,
    parameter int DWELL_W = 8,
    parameter int GAP_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [2:0]               in_code,
    output logic                     in_ready,
    input  logic [DWELL_W-1:0]       dwell,
    input  logic [GAP_W-1:0]         gap,
    output logic [7:0]               Q,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     done_pulse
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (DWELL_W > GAP_W) ? DWELL_W : GAP_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHOW,
        S_GAP
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [7:0]      r_q;
    logic [7:0]      w_q_nxt;
    logic            r_done;

    logic [2:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;

    logic            w_wr;
    logic            w_pop;
    logic            w_start;
    logic            w_have;
    logic            w_gap_on;
    logic [2:0]      w_head;
    logic [CW-1:0]   w_dwell_ld;
    logic [CW-1:0]   w_gap_ld;

    assign in_ready   = (r_level != LW'(DEPTH));
    assign w_wr       = in_valid && in_ready;
    assign w_have     = (r_level != '0);
    assign w_head     = r_mem[r_rd_ptr];
    assign w_gap_on   = (gap != '0);
    // A dwell of 0 behaves like 1, so the shortest code still holds for one cycle.
    assign w_dwell_ld = (dwell == '0) ? '0 : CW'(dwell - DWELL_W'(1));
    assign w_gap_ld   = CW'(gap - GAP_W'(1));

    assign Q          = r_q;
    assign busy       = (r_state != S_IDLE);
    assign level      = r_level;
    assign done_pulse = r_done;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_q_nxt     = r_q;
        w_start     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_q_nxt = '0;
                w_start = w_have;
            end
            S_SHOW: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end else if (w_gap_on) begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = w_gap_ld;
                    w_q_nxt     = '0;
                end else if (w_have) begin
                    w_start = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_q_nxt     = '0;
                end
            end
            S_GAP: begin
                w_q_nxt = '0;
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end else if (w_have) begin
                    w_start = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_q_nxt     = '0;
            end
        endcase

        if (w_start) begin
            w_state_nxt = S_SHOW;
            w_cnt_nxt   = w_dwell_ld;
            w_q_nxt     = 8'd1 << w_head;
        end
    end

    assign w_pop = w_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_q      <= '0;
            r_done   <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_q     <= w_q_nxt;
            // Registered so the pulse lines up with the final cycle a code is on Q.
            r_done  <= (w_state_nxt == S_SHOW) && (w_cnt_nxt == '0);
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // NOTE: storage is not reset; the pointers and level define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= in_code;
        end
    end

endmodule

// File: tb/tb_dec38_seq.sv
// Scoreboard bench for dec38_seq: the stimulus pushes the expected codes, and a
// monitor checks the value, hold length, gap length and back-to-back timing of each code.
module tb_dec38_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] in_code;
    logic       in_ready;
    logic [7:0] dwell;
    logic [3:0] gap;
    logic [7:0] Q;
    logic       busy;
    logic [2:0] level;
    logic       done_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] q;
        int         hold;
        int         gap;
        bit         b2b;
    } exp_t;

    exp_t exp_q[$];

    dec38_seq #(.DEPTH(4), .DWELL_W(8), .GAP_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_code   (in_code),
        .in_ready  (in_ready),
        .dwell     (dwell),
        .gap       (gap),
        .Q         (Q),
        .busy      (busy),
        .level     (level),
        .done_pulse(done_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_code(input logic [7:0] q, input int hold, input int g, input bit b2b);
        exp_t e;
        e.q = q; e.hold = hold; e.gap = g; e.b2b = b2b;
        exp_q.push_back(e);
    endtask

    // Call from a point away from the rising edge; returns 1 time unit after the accepting edge.
    task automatic send(input logic [2:0] c);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_code  = c;
        for (int n = 0; n < 1000; n++) begin
            ok = in_ready;
            @(posedge clk);
            if (ok) break;
        end
        check("send_accept", 32'(ok), 32'd1);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (!busy && level == 3'd0) begin
                idle = 1'b1;
                break;
            end
        end
        check("wait_idle", 32'(idle), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: tracks runs of a nonzero Q and closes each code on done_pulse.
    int         cyc = 0;
    int         run_start = 0;
    int         run_len = 0;
    int         last_done = -10;
    int         gap_cnt = 0;
    int         exp_gap = 0;
    bit         gap_pending = 1'b0;
    logic [7:0] prev_q = '0;
    logic       prev_done = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            gap_pending = 1'b0;
            prev_q      = '0;
            prev_done   = 1'b0;
        end else begin
            if (Q != 8'h00) begin
                if (prev_q == 8'h00 || Q != prev_q || prev_done) begin
                    if (gap_pending) begin
                        check("gap_len", 32'(gap_cnt), 32'(exp_gap));
                        gap_pending = 1'b0;
                    end
                    run_start = cyc;
                    run_len   = 1;
                end else begin
                    run_len++;
                end
            end else if (busy) begin
                gap_cnt++;
            end else if (gap_pending) begin
                check("gap_len", 32'(gap_cnt), 32'(exp_gap));
                gap_pending = 1'b0;
            end

            if (done_pulse) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(Q), 32'h0);
                    check("unexpected_done_cnt", 32'd1, 32'(exp_q.size()));
                end else begin
                    e = exp_q.pop_front();
                    check("code_q", 32'(Q), 32'(e.q));
                    check("code_hold", 32'(run_len), 32'(e.hold));
                    if (e.b2b) check("back_to_back", 32'(run_start), 32'(last_done + 1));
                    gap_pending = 1'b1;
                    exp_gap     = e.gap;
                    gap_cnt     = 0;
                end
                last_done = cyc;
            end
            prev_q    = Q;
            prev_done = done_pulse;
        end
    end

    initial begin
        bit stale;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_code  = '0;
        dwell    = 8'd1;
        gap      = 4'd0;
        #23;
        check("rst_q", 32'(Q), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_level", 32'(level), 32'h0);
        check("rst_done", 32'(done_pulse), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'h1);

        // Single code 3, dwell 4, gap 2: Q valid two cycles after the write cycle.
        dwell = 8'd4;
        gap   = 4'd2;
        expect_code(8'h08, 4, 2, 1'b0);
        send(3'd3);
        @(negedge clk);
        check("lat_cycle1_q", 32'(Q), 32'h0);
        check("lat_cycle1_level", 32'(level), 32'h1);
        @(negedge clk);
        check("lat_cycle2_q", 32'(Q), 32'h08);
        wait_idle();

        // Sweep 0..7 with dwell 1, gap 0: one code per cycle, no blanks.
        dwell = 8'd1;
        gap   = 4'd0;
        for (int i = 0; i < 8; i++) expect_code(8'd1 << i, 1, 0, i != 0);
        for (int i = 0; i < 8; i++) send(3'(i));
        wait_idle();

        // Dwell 0 is treated as 1.
        dwell = 8'd0;
        expect_code(8'h80, 1, 0, 1'b0);
        send(3'd7);
        wait_idle();

        // Dwell changed while the first code shows: it keeps 3, the next gets 10.
        dwell = 8'd3;
        expect_code(8'h01, 3, 0, 1'b0);
        expect_code(8'h02, 10, 0, 1'b1);
        send(3'd0);
        send(3'd1);
        dwell = 8'd10;
        wait_idle();

        // Fill the FIFO behind a long dwell; order must survive pointer wrap.
        dwell = 8'd200;
        gap   = 4'd0;
        expect_code(8'h04, 200, 0, 1'b0);
        expect_code(8'h10, 200, 0, 1'b1);
        expect_code(8'h40, 200, 0, 1'b1);
        expect_code(8'h02, 200, 0, 1'b1);
        expect_code(8'h08, 200, 0, 1'b1);
        expect_code(8'h20, 200, 0, 1'b1);
        send(3'd2);
        send(3'd4);
        send(3'd6);
        send(3'd1);
        send(3'd3);
        check("full_level", 32'(level), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_code  = 3'd5;
        repeat (50) @(posedge clk);
        #1;
        check("full_hold_level", 32'(level), 32'd4);
        send(3'd5);
        wait_idle();

        // Asynchronous reset in the middle of SHOW with two codes queued.
        dwell = 8'd200;
        send(3'd1);
        send(3'd2);
        send(3'd3);
        repeat (5) @(negedge clk);
        check("pre_rst_level", 32'(level), 32'd2);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_q", 32'(Q), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        check("async_rst_level", 32'(level), 32'h0);
        check("async_rst_in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (Q != 8'h00 || busy) stale = 1'b1;
        end
        check("no_stale_after_rst", 32'(stale), 32'h0);
        check("post_rst_level", 32'(level), 32'h0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
